// File: rtl/frame_loader.sv
// UART (8N1) frame receiver: sync byte 0xA5 followed by 12-bit channel values
// packed two per three bytes, written sequentially into a framebuffer.
module frame_loader #(
  parameter int c_ledboards    = 30,
  parameter int c_bpc          = 12,
  parameter int c_div          = 16,
  parameter int c_timeout_bits = 40
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_rx,
  output logic                                o_wen,
  output logic [$clog2(c_ledboards*32)-1:0]   o_waddr,
  output logic [c_bpc-1:0]                    o_wdata,
  output logic                                o_frame_done,
  output logic                                o_err
);

  localparam int C_CHANNELS = c_ledboards * 32;
  localparam int AW         = $clog2(C_CHANNELS);
  localparam int TMO        = c_timeout_bits * c_div;
  localparam int TW         = $clog2(TMO + 1);

  localparam logic [7:0]    HALF_M1 = 8'(c_div / 2 - 1);
  localparam logic [7:0]    BIT_M1  = 8'(c_div - 1);
  localparam logic [AW-1:0] LAST    = AW'(C_CHANNELS - 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(TMO - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {S_SYNC, S_B0, S_B1, S_B2} fr_state_t;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            strobe, ferr, tmo;

  fr_state_t       fr_q, fr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      b0_q, b0_d, b1_q, b1_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            wen_q, wen_d, done_q, done_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [c_bpc-1:0] wdata_q, wdata_d;
  logic            wr;
  logic [c_bpc-1:0] wval;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= i_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    strobe     = 1'b0;
    ferr       = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = R_START;
          cnt_d      = HALF_M1;
        end
      end
      R_START: begin
        if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
        else if (rx_s2_q) rx_state_d = R_IDLE;
        else begin
          rx_state_d = R_DATA;
          cnt_d      = BIT_M1;
          bit_d      = '0;
        end
      end
      R_DATA: begin
        if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
        else begin
          sh_d  = {rx_s2_q, sh_q[7:1]};
          cnt_d = BIT_M1;
          if (bit_q == 3'd7) rx_state_d = R_STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      default: begin
        if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
        else begin
          rx_state_d = R_IDLE;
          if (rx_s2_q) strobe = 1'b1;
          else ferr = 1'b1;
        end
      end
    endcase
  end

  // A strobe in the same cycle as the timeout threshold counts as activity.
  assign tmo = (fr_q != S_SYNC) && (tcnt_q == TMO_M1) && !strobe;

  always_comb begin
    fr_d    = fr_q;
    addr_d  = addr_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    tcnt_d  = '0;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wr      = 1'b0;
    wval    = wdata_q;
    if (fr_q != S_SYNC && !strobe) tcnt_d = tcnt_q + TW'(1);
    if (strobe) begin
      case (fr_q)
        S_SYNC: if (sh_q == 8'hA5) fr_d = S_B0;
        S_B0: begin
          b0_d = sh_q;
          fr_d = S_B1;
        end
        S_B1: begin
          b1_d = sh_q;
          wr   = 1'b1;
          wval = {b0_q, sh_q[7:4]};
          fr_d = S_B2;
        end
        default: begin
          wr   = 1'b1;
          wval = {b1_q[3:0], sh_q};
          fr_d = S_B0;
        end
      endcase
    end
    if (wr) begin
      wen_d   = 1'b1;
      waddr_d = addr_q;
      wdata_d = wval;
      if (addr_q == LAST) begin
        done_d = 1'b1;
        fr_d   = S_SYNC;
        addr_d = '0;
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end
    if (ferr || tmo) begin
      fr_d   = S_SYNC;
      addr_d = '0;
      tcnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state_q <= R_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      fr_q       <= S_SYNC;
      addr_q     <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      tcnt_q     <= '0;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      fr_q       <= fr_d;
      addr_q     <= addr_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      tcnt_q     <= tcnt_d;
      wen_q      <= wen_d;
      done_q     <= done_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign o_wen        = wen_q;
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign o_frame_done = done_q;
  assign o_err        = ferr | tmo;

endmodule
